// File: rtl/scan_pkg.sv
// Shared types and defaults for the scan chain controller slice.
package scan_pkg;

    localparam int DEF_CHAIN_LEN = 8;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CAPTURE,
        UNLOAD,
        DONE
    } scan_state_t;

endpackage

// File: rtl/scan_resp_cmp.sv
// Response side of the scan controller: unload shift register, masked
// compare against the expected state, and the saturating failure counter.
module scan_resp_cmp #(
    parameter int CHAIN_LEN = 8,
    parameter int FAIL_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 unload,
    input  logic                 finish,
    input  logic                 chain_so,
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic [CHAIN_LEN-1:0] mask,
    output logic [CHAIN_LEN-1:0] response,
    output logic                 pass,
    output logic [FAIL_W-1:0]    fail_count
);

    logic [CHAIN_LEN-1:0] shift_q;
    logic [CHAIN_LEN-1:0] shift_d;
    logic                 miss;

    // The first bit unloaded comes from flop CHAIN_LEN-1, so after
    // CHAIN_LEN left shifts every bit sits at its own flop index.
    generate
        if (CHAIN_LEN == 1) begin : g_single
            assign shift_d = chain_so;
        end else begin : g_multi
            assign shift_d = {shift_q[CHAIN_LEN-2:0], chain_so};
        end
    endgenerate

    assign miss = |((shift_d ^ expected) & mask);

    // response/pass only move on the final unload edge so they hold steady
    // between patterns and are already valid while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q    <= '0;
            response   <= '0;
            pass       <= 1'b0;
            fail_count <= '0;
        end else begin
            if (unload) begin
                shift_q <= shift_d;
            end
            if (finish) begin
                response <= shift_d;
                pass     <= !miss;
                if (miss && (fail_count != {FAIL_W{1'b1}})) begin
                    fail_count <= fail_count + FAIL_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Sequences one test pattern at a time through a serial mux-D scan chain:
// shift in, capture one functional cycle, shift out and compare under mask.
module scan_chain_ctrl
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1),
    parameter int FAIL_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic [CHAIN_LEN-1:0] mask,
    input  logic                 chain_so,
    output logic                 scan_en,
    output logic                 chain_si,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] response,
    output logic                 pass,
    output logic [FAIL_W-1:0]    fail_count
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

    scan_state_t          state;
    scan_state_t          state_d;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_d;
    logic [CNT_W-1:0]     si_idx;
    logic [CHAIN_LEN-1:0] pat_q;
    logic [CHAIN_LEN-1:0] exp_q;
    logic [CHAIN_LEN-1:0] mask_q;
    logic [CHAIN_LEN-1:0] pat_d;
    logic [CHAIN_LEN-1:0] pat_sel;
    logic                 accept;
    logic                 last;
    logic                 scan_en_d;
    logic                 chain_si_d;

    assign accept = (state == IDLE) && start;
    assign last   = (count == LAST_CNT);
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

    always_comb begin
        state_d = state;
        count_d = count;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    count_d = '0;
                end
            end
            SHIFT: begin
                if (last) begin
                    state_d = CAPTURE;
                    count_d = '0;
                end else begin
                    count_d = count + CNT_W'(1);
                end
            end
            CAPTURE: begin
                state_d = UNLOAD;
                count_d = '0;
            end
            UNLOAD: begin
                if (last) begin
                    state_d = DONE;
                    count_d = '0;
                end else begin
                    count_d = count + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // Pin drivers are computed from the next state so they can be registered
    // yet still line up with the state they belong to (MSB shifted first).
    always_comb begin
        pat_d      = accept ? pattern : pat_q;
        si_idx     = LAST_CNT - count_d;
        pat_sel    = pat_d >> si_idx;
        scan_en_d  = (state_d == SHIFT) || (state_d == UNLOAD);
        chain_si_d = (state_d == SHIFT) ? pat_sel[0] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            scan_en  <= 1'b0;
            chain_si <= 1'b0;
            pat_q    <= '0;
            exp_q    <= '0;
            mask_q   <= '0;
        end else begin
            state    <= state_d;
            count    <= count_d;
            scan_en  <= scan_en_d;
            chain_si <= chain_si_d;
            if (accept) begin
                pat_q  <= pattern;
                exp_q  <= expected;
                mask_q <= mask;
            end
        end
    end

    scan_resp_cmp #(
        .CHAIN_LEN (CHAIN_LEN),
        .FAIL_W    (FAIL_W)
    ) u_resp_cmp (
        .clk        (clk),
        .rst        (rst),
        .unload     (state == UNLOAD),
        .finish     ((state == UNLOAD) && last),
        .chain_so   (chain_so),
        .expected   (exp_q),
        .mask       (mask_q),
        .response   (response),
        .pass       (pass),
        .fail_count (fail_count)
    );

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: a 4-flop chain (D tied by the bench) and a
// 1-flop chain with a 2-bit failure counter, each with its own chain model.
module tb_scan_chain_ctrl;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic         start = 1'b0;
    logic [N-1:0] pattern = '0;
    logic [N-1:0] expected = '0;
    logic [N-1:0] mask = '0;
    logic         chain_so;
    logic         scan_en;
    logic         chain_si;
    logic         busy;
    logic         done;
    logic [N-1:0] response;
    logic         pass;
    logic [7:0]   fail_count;

    logic         start1 = 1'b0;
    logic [0:0]   pattern1 = '0;
    logic [0:0]   expected1 = '0;
    logic [0:0]   mask1 = '0;
    logic         chain_so1;
    logic         scan_en1;
    logic         chain_si1;
    logic         busy1;
    logic         done1;
    logic [0:0]   response1;
    logic         pass1;
    logic [1:0]   fail_count1;

    logic [N-1:0] func_d = 4'b1010;
    logic [N-1:0] chain = '0;
    logic         chain1 = 1'b0;

    int checks = 0;
    int errors = 0;
    int model_fails = 0;
    int model_fails1 = 0;

    always #5 clk = ~clk;

    scan_chain_ctrl #(.CHAIN_LEN(N), .FAIL_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern),
        .expected(expected), .mask(mask), .chain_so(chain_so),
        .scan_en(scan_en), .chain_si(chain_si), .busy(busy), .done(done),
        .response(response), .pass(pass), .fail_count(fail_count)
    );

    scan_chain_ctrl #(.CHAIN_LEN(1), .FAIL_W(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .pattern(pattern1),
        .expected(expected1), .mask(mask1), .chain_so(chain_so1),
        .scan_en(scan_en1), .chain_si(chain_si1), .busy(busy1), .done(done1),
        .response(response1), .pass(pass1), .fail_count(fail_count1)
    );

    // Mux-D scan flops: shift toward the top flop when scan_en, else load D.
    always @(posedge clk) begin
        if (scan_en) chain <= {chain[N-2:0], chain_si};
        else         chain <= func_d;
        if (scan_en1) chain1 <= chain_si1;
        else          chain1 <= 1'b1;
    end
    assign chain_so  = chain[N-1];
    assign chain_so1 = chain1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full pattern on the 4-flop chain, checked against the plain rules:
    // pattern bits leave MSB first, captured D comes back, masked compare.
    task automatic applyStimulus(input logic [N-1:0] pat, input logic [N-1:0] exp_v,
                                 input logic [N-1:0] msk, input logic [N-1:0] dval,
                                 input bit scramble);
        int cycles;
        logic exp_pass;
        func_d   = dval;
        pattern  = pat;
        expected = exp_v;
        mask     = msk;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            checkOutput("shift_si", 32'(chain_si), 32'(pat[N-1-i]));
            checkOutput("shift_en", 32'(scan_en), 32'd1);
            if (scramble) begin
                pattern  = ~pat;
                expected = ~exp_v;
                mask     = ~msk;
            end
            step();
        end
        checkOutput("capture_en", 32'(scan_en), 32'd0);
        checkOutput("capture_si", 32'(chain_si), 32'd0);
        checkOutput("capture_busy", 32'(busy), 32'd1);
        cycles = N + 1;
        while (done !== 1'b1 && cycles < 2 * N + 6) begin
            step();
            cycles++;
        end
        checkOutput("latency", 32'(cycles), 32'(2 * N + 2));
        exp_pass = (((dval ^ exp_v) & msk) == '0);
        if (!exp_pass && model_fails < 255) model_fails++;
        checkOutput("response", 32'(response), 32'(dval));
        checkOutput("pass", 32'(pass), 32'(exp_pass));
        checkOutput("fail_count", 32'(fail_count), 32'(model_fails));
        step();
        checkOutput("done_pulse", 32'(done), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("hold_response", 32'(response), 32'(dval));
    endtask

    task automatic applyOne(input logic exp_v, input logic msk);
        int cycles;
        logic exp_pass;
        pattern1  = 1'b0;
        expected1 = exp_v;
        mask1     = msk;
        start1    = 1'b1;
        step();
        start1 = 1'b0;
        checkOutput("one_shift_en", 32'(scan_en1), 32'd1);
        cycles = 1;
        while (done1 !== 1'b1 && cycles < 10) begin
            step();
            cycles++;
        end
        checkOutput("one_latency", 32'(cycles), 32'd4);
        exp_pass = ((1'b1 ^ exp_v) & msk) == 1'b0;
        if (!exp_pass && model_fails1 < 3) model_fails1++;
        checkOutput("one_response", 32'(response1), 32'd1);
        checkOutput("one_pass", 32'(pass1), 32'(exp_pass));
        checkOutput("one_fail_count", 32'(fail_count1), 32'(model_fails1));
        step();
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_scan_en"}, 32'(scan_en), 32'd0);
        checkOutput({tag, "_chain_si"}, 32'(chain_si), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_response"}, 32'(response), 32'd0);
        checkOutput({tag, "_pass"}, 32'(pass), 32'd0);
        checkOutput({tag, "_fail_count"}, 32'(fail_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t_prev;
        int t_now;
        int cyc;
        logic [N-1:0] rp, rd, rm, re;

        rst = 1'b1;
        step();
        step();
        checkReset("reset");
        checkOutput("reset_fail1", 32'(fail_count1), 32'd0);
        rst = 1'b0;
        step();

        applyStimulus(4'b0110, 4'b1010, 4'hF, 4'b1010, 1'b0);
        applyStimulus(4'b0110, 4'b1000, 4'hF, 4'b1010, 1'b0);
        applyStimulus(4'b1001, 4'b1000, 4'b1101, 4'b1010, 1'b1);

        // start held high: one done every 11 cycles
        func_d   = 4'b0011;
        pattern  = 4'b0101;
        expected = 4'b0011;
        mask     = 4'hF;
        start    = 1'b1;
        cyc      = 0;
        t_prev   = -1;
        for (int k = 0; k < 3; k++) begin
            while (done !== 1'b1 && cyc < 200) begin
                step();
                cyc++;
            end
            t_now = cyc;
            if (t_prev >= 0) checkOutput("held_period", 32'(t_now - t_prev), 32'd11);
            checkOutput("held_response", 32'(response), 32'b0011);
            checkOutput("held_fail_count", 32'(fail_count), 32'(model_fails));
            t_prev = t_now;
            step();
            cyc++;
        end
        start = 1'b0;
        step();
        step();

        for (int r = 0; r < 8; r++) begin
            rp = 4'($urandom);
            rd = 4'($urandom);
            rm = 4'($urandom);
            re = ($urandom_range(0, 1) == 0) ? rd : 4'($urandom);
            applyStimulus(rp, re, rm, rd, r[0]);
        end

        // reset during UNLOAD aborts everything
        applyStimulus(4'b1111, 4'b0000, 4'hF, 4'b0110, 1'b0);
        func_d   = 4'b1100;
        pattern  = 4'b0011;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < N + 2; i++) step();
        checkOutput("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_fails  = 0;
        model_fails1 = 0;
        checkReset("abort");
        step();
        applyStimulus(4'b0110, 4'b1010, 4'hF, 4'b1010, 1'b0);

        // 1-flop chain, 2-bit counter saturates
        for (int k = 0; k < 4; k++) applyOne(1'b0, 1'b1);
        applyOne(1'b1, 1'b1);
        applyOne(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
- Sequences test patterns through a single serial scan chain of the team's mux-D scan flip-flops.
- Per pattern: shift in, one functional capture cycle, shift out, then compare against expected data under a mask.
- Sits between the test-access logic, which supplies patterns and reads results, and the chain's scan_en/scan_in/scan_out pins.
- One pattern per start; no overlap of unload with the next load.

Parameters:
- CHAIN_LEN, 8, number of flops in the chain (≥1).
- CNT_W, $clog2(CHAIN_LEN+1), width of the internal shift counter.
- FAIL_W, 8, width of the saturating failed-pattern counter.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request one pattern; accepted only in IDLE
- pattern  input  CHAIN_LEN  stimulus; bit i ends in chain flop i (flop 0 fed by scan_in, flop CHAIN_LEN-1 drives scan_out)
- expected  input  CHAIN_LEN  expected captured state, same bit mapping
- mask  input  CHAIN_LEN  1 = compare bit, 0 = don't care
- chain_so  input  1  chain scan_out
- scan_en  output  1  chain scan enable
- chain_si  output  1  chain scan_in
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse when result valid
- response  output  CHAIN_LEN  unloaded captured state
- pass  output  1  ((response ^ expected) & mask) == 0; valid from done onward
- fail_count  output  FAIL_W  patterns failed since reset; saturates at all-ones

Behaviour:
- Reset (rst=1 at edge): state=IDLE, counter=0; scan_en=0, chain_si=0, busy=0, done=0, response=0, pass=0, fail_count=0.
- Reset mid-operation aborts immediately. Chain contents are not restored.
- States: IDLE, SHIFT, CAPTURE, UNLOAD, DONE.
- IDLE:
  - scan_en=0.
  - start=1 latches pattern/expected/mask into internal regs, then goes to SHIFT, counter=0.
  - Input changes after acceptance have no effect.
- SHIFT: CHAIN_LEN cycles.
  - scan_en=1.
  - chain_si = latched_pattern[CHAIN_LEN-1-counter], so MSB is shifted first.
  - After the last shift cycle, go to CAPTURE.
- CAPTURE: exactly 1 cycle, scan_en=0, chain_si=0. Chain loads functional D.
- UNLOAD: CHAIN_LEN cycles.
  - scan_en=1, chain_si=0 (chain flushed to zero).
  - Each edge: response <= {response[CHAIN_LEN-2:0], chain_so}. For CHAIN_LEN=1: response <= chain_so.
  - After the last cycle, go to DONE.
- DONE: 1 cycle.
  - done=1, scan_en=0; pass computed from the final response.
  - If !pass, fail_count increments unless saturated.
  - Then go to IDLE.
- Latency: start sampled at edge T.
  - scan_en=1 for cycles T+1..T+N.
  - CAPTURE at T+N+1.
  - UNLOAD at T+N+2..T+2N+1.
  - done at T+2N+2.
  - start-to-done = 2N+2 cycles (N=CHAIN_LEN).
- start while busy is ignored, not queued.
- start in the same cycle done=1 is ignored; it is accepted on the next cycle, when the block is in IDLE.
- response and pass hold their values until the next DONE or reset.
- Counter compares against CHAIN_LEN-1; CNT_W must be ≥1 when CHAIN_LEN=1.
- chain_si and scan_en are registered outputs: no combinational path from inputs.

Decomposition:
- Shared package scan_pkg: state enum (IDLE, SHIFT, CAPTURE, UNLOAD, DONE) and the default CHAIN_LEN.
- Natural sub-module: scan_resp_cmp, containing the response shift register, masked compare and saturating fail counter. The FSM and counter stay in the top module.

Test Plan:
- Bench setup: CHAIN_LEN=4 chain of the team's scan flops; functional D of flops 3..0 tied to 4'b1010.
- Load/unload check: pattern=4'b0110, start → chain_si sequence 0,1,1,0 over cycles T+1..T+4 with scan_en=1; scan_en=0 at T+5; response=4'b1010 with done at T+10.
- Pass/fail with mask: expected=4'b1010, mask=4'hF → pass=1, fail_count=0. Then expected=4'b1000, mask=4'hF → pass=0, fail_count=1. Then expected=4'b1000, mask=4'b1101 → pass=1, fail_count stays 1.
- start held high continuously → exactly one done per 11 cycles (10-cycle sequence plus 1 IDLE accept cycle); pattern changed during SHIFT has no effect on chain_si.
- rst=1 asserted during UNLOAD → next cycle: state IDLE, scan_en=0, busy=0, response=0, fail_count=0; a new start then completes normally.
- FAIL_W=2, four consecutive failing patterns → fail_count 1, 2, 3, 3 (saturates).
- CHAIN_LEN=1 build, D tied to 1 → done at T+4, response=1'b1.
